sha256_host_if: RTL and testbench

//  Host-side driver for the SHA-256 core controller. Collects pre-padded message words from an upstream

---
 rtl/sha256_host_if_if.sv | 47 ++++
 rtl/sha256_host_if.sv | 240 ++++++++++++++++++++++++
 tb/tb_sha256_host_if.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_host_if_if.sv
// -----------------------------------------------------------------------------
// sha256_host_if_if
// Bundles the three buses of the SHA-256 host driver into one interface:
//   upstream word stream   : s_valid, s_ready, s_data[31:0], s_last
//   core load/status port  : core_data[31:0], core_data_valid, core_first_block,
//                            core_last_block, core_busy, core_inner_busy,
//                            core_output_enable, core_digest_byte[7:0]
//   downstream digest port : m_valid, m_ready, m_digest[255:0]
// Modports:
//   master : the host driver (drives s_ready, core_* loads, m_valid/m_digest)
//   slave  : the surrounding environment (upstream source, core, sink)
// -----------------------------------------------------------------------------
interface sha256_host_if_if;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         s_last;
  logic [31:0]  core_data;
  logic         core_data_valid;
  logic         core_first_block;
  logic         core_last_block;
  logic         core_busy;
  logic         core_inner_busy;
  logic         core_output_enable;
  logic [7:0]   core_digest_byte;
  logic         m_valid;
  logic         m_ready;
  logic [255:0] m_digest;

  modport master (
    input  s_valid, s_data, s_last,
    output s_ready,
    output core_data, core_data_valid, core_first_block, core_last_block,
    input  core_busy, core_inner_busy, core_output_enable, core_digest_byte,
    output m_valid, m_digest,
    input  m_ready
  );

  modport slave (
    output s_valid, s_data, s_last,
    input  s_ready,
    input  core_data, core_data_valid, core_first_block, core_last_block,
    output core_busy, core_inner_busy, core_output_enable, core_digest_byte,
    input  m_valid, m_digest,
    output m_ready
  );
endinterface

// File: rtl/sha256_host_if.sv
// -----------------------------------------------------------------------------
// sha256_host_if
// Host-side driver for a SHA-256 core. Buffers 16 pre-padded words per block
// from the upstream stream, replays them to the core over 16 contiguous cycles
// with first/last-block strobes, waits for the core, collects the 32 digest
// bytes from the core's output window and hands the 256-bit digest downstream.
// Ports:
//   clk          : clock, rising edge
//   reset_n      : asynchronous active-low reset
//   bus          : sha256_host_if_if.master (stream, core and digest buses)
//   busy         : high in every state except IDLE
//   timeout_err  : one-cycle pulse when the core fails to respond in WAIT
// All outputs are flops loaded from the next-state values, so each output
// changes in the same cycle as the state it belongs to.
// -----------------------------------------------------------------------------
module sha256_host_if #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  sha256_host_if_if.master   bus,
  output logic               busy,
  output logic               timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      widx_q, widx_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [4:0]      bcnt_q, bcnt_d;
  logic            first_pending_q, first_pending_d;
  logic            last_blk_q, last_blk_d;
  logic            seen_busy_q, seen_busy_d;
  logic [255:0]    digest_q, digest_d;
  logic [31:0]     buf_q [16];
  logic            buf_we_s;
  logic [7:0]      cap_byte_s;

  logic            s_ready_q;
  logic [31:0]     core_data_q;
  logic            core_data_valid_q;
  logic            core_first_q;
  logic            core_last_q;
  logic            m_valid_q;
  logic            busy_q;
  logic            timeout_err_q;

  // A byte missing from a short output window is taken as zero.
  assign cap_byte_s = bus.core_output_enable ? bus.core_digest_byte : 8'h00;

  // Next-state and datapath control for the block/digest sequencer.
  always_comb begin
    state_d         = state_q;
    widx_d          = widx_q;
    cnt_d           = cnt_q;
    to_cnt_d        = '0;
    bcnt_d          = bcnt_q;
    first_pending_d = first_pending_q;
    last_blk_d      = last_blk_q;
    seen_busy_d     = seen_busy_q;
    digest_d        = digest_q;
    buf_we_s        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!bus.core_busy) begin
          state_d = ST_FILL;
          widx_d  = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FILL: begin
        if (bus.s_valid) begin
          buf_we_s = 1'b1;
          widx_d   = widx_q + 4'd1;
          // s_last only has meaning alongside the block's final word.
          if (widx_q == 4'd15) begin
            last_blk_d = bus.s_last;
            state_d    = ST_SEND;
            cnt_d      = 4'd0;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_FILL;
        end
      end

      ST_SEND: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d         = ST_WAIT;
          first_pending_d = 1'b0;
          seen_busy_d     = 1'b0;
        end else begin
          state_d = ST_SEND;
        end
      end

      ST_WAIT: begin
        to_cnt_d = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
        // Timeout wins over any core progress seen in the same cycle.
        if (to_cnt_q == TO_W'(TIMEOUT_CYCLES)) begin
          state_d         = ST_IDLE;
          first_pending_d = 1'b1;
          widx_d          = 4'd0;
          to_cnt_d        = '0;
        end else if (last_blk_q) begin
          // The byte on the bus in the window's first cycle is digest byte 0.
          if (bus.core_output_enable) begin
            state_d  = ST_CAPTURE;
            digest_d = {digest_q[247:0], cap_byte_s};
            bcnt_d   = 5'd1;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          // Leave only after the compression has been seen running and ended.
          if (bus.core_inner_busy) begin
            seen_busy_d = 1'b1;
            state_d     = ST_WAIT;
          end else if (seen_busy_q) begin
            state_d     = ST_FILL;
            widx_d      = 4'd0;
            seen_busy_d = 1'b0;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_CAPTURE: begin
        digest_d = {digest_q[247:0], cap_byte_s};
        bcnt_d   = bcnt_q + 5'd1;
        if (bcnt_q == 5'd31) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CAPTURE;
        end
      end

      ST_DONE: begin
        if (bus.m_ready) begin
          state_d         = ST_IDLE;
          first_pending_d = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, counters and digest shift register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      widx_q          <= 4'd0;
      cnt_q           <= 4'd0;
      to_cnt_q        <= '0;
      bcnt_q          <= 5'd0;
      first_pending_q <= 1'b1;
      last_blk_q      <= 1'b0;
      seen_busy_q     <= 1'b0;
      digest_q        <= 256'h0;
    end else begin
      state_q         <= state_d;
      widx_q          <= widx_d;
      cnt_q           <= cnt_d;
      to_cnt_q        <= to_cnt_d;
      bcnt_q          <= bcnt_d;
      first_pending_q <= first_pending_d;
      last_blk_q      <= last_blk_d;
      seen_busy_q     <= seen_busy_d;
      digest_q        <= digest_d;
    end
  end

  // Block buffer written one word per accepted upstream beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        buf_q[i] <= 32'h0;
      end
    end else if (buf_we_s) begin
      buf_q[widx_q] <= bus.s_data;
    end else begin
      buf_q[widx_q] <= buf_q[widx_q];
    end
  end

  // Output flops loaded from next-state values so they line up with state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_ready_q         <= 1'b0;
      core_data_q       <= 32'h0;
      core_data_valid_q <= 1'b0;
      core_first_q      <= 1'b0;
      core_last_q       <= 1'b0;
      m_valid_q         <= 1'b0;
      busy_q            <= 1'b0;
      timeout_err_q     <= 1'b0;
    end else begin
      s_ready_q         <= (state_d == ST_FILL);
      core_data_valid_q <= (state_d == ST_SEND);
      core_data_q       <= (state_d == ST_SEND) ? buf_q[cnt_d] : 32'h0;
      core_first_q      <= (state_d == ST_SEND) && (cnt_d == 4'd0) && first_pending_d;
      core_last_q       <= (state_d == ST_SEND) && (cnt_d == 4'd0) && last_blk_d;
      m_valid_q         <= (state_d == ST_DONE);
      busy_q            <= (state_d != ST_IDLE);
      timeout_err_q     <= (state_d == ST_WAIT) && (to_cnt_d == TO_W'(TIMEOUT_CYCLES));
    end
  end

  assign bus.s_ready          = s_ready_q;
  assign bus.core_data        = core_data_q;
  assign bus.core_data_valid  = core_data_valid_q;
  assign bus.core_first_block = core_first_q;
  assign bus.core_last_block  = core_last_q;
  assign bus.m_valid          = m_valid_q;
  assign bus.m_digest         = digest_q;
  assign busy                 = busy_q;
  assign timeout_err          = timeout_err_q;

endmodule

// File: tb/tb_sha256_host_if.sv
// -----------------------------------------------------------------------------
// tb_sha256_host_if
// Directed bench for sha256_host_if. A table of block records (words, s_last,
// expected strobes, expected digest) is replayed through the DUT while the
// bench plays the SHA-256 core; hand-written sequences cover backpressure in
// DONE, a short output window, the WAIT timeout and a reset during SEND.
// -----------------------------------------------------------------------------
module tb_sha256_host_if;

  localparam int TIMEOUT_CYCLES = 255;

  typedef struct packed {
    logic [511:0] blk;
    logic         last;
    logic         exp_first;
    logic         exp_last;
    logic         toggle;
    logic [255:0] digest;
  } vec_t;

  logic clk;
  logic reset_n;
  logic busy;
  logic timeout_err;
  int   checks;
  int   failures;
  vec_t vecs [4];

  sha256_host_if_if bus ();

  sha256_host_if #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] wd(input vec_t v, input int i);
    return v.blk[511-32*i -: 32];
  endfunction

  // Upstream source: 16 words, optional one-idle-cycle gap before each word.
  task automatic push_words(input vec_t v);
    int n;
    for (int i = 0; i < 16; i++) begin
      if (v.toggle) begin
        bus.s_valid = 1'b0;
        tick();
      end
      bus.s_valid = 1'b1;
      bus.s_data  = wd(v, i);
      bus.s_last  = (i == 15) ? v.last : ~v.last;
      n = 0;
      while (!bus.s_ready && n < 64) begin
        tick();
        n++;
      end
      chk("fill_s_ready", bus.s_ready, 1'b1);
      tick();
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = 32'h0;
  endtask

  // Core-side view of SEND, starting the cycle after the last word was taken.
  task automatic check_send(input vec_t v, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      chk("send_valid", bus.core_data_valid, 1'b1);
      chk("send_data", bus.core_data, wd(v, c));
      chk("send_first", bus.core_first_block, (c == 0) ? v.exp_first : 1'b0);
      chk("send_last", bus.core_last_block, (c == 0) ? v.exp_last : 1'b0);
      tick();
    end
  endtask

  // Model core: compression pulse for an inner block.
  task automatic core_inner();
    bus.core_inner_busy = 1'b0;
    tick();
    tick();
    chk("wait_no_rise", bus.s_ready, 1'b0);
    bus.core_inner_busy = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("wait_inner_busy", bus.s_ready, 1'b0);
    bus.core_inner_busy = 1'b0;
    tick();
    chk("wait_to_fill", bus.s_ready, 1'b1);
  endtask

  // Model core: digest window of oe_bytes valid bytes, then downstream handshake.
  task automatic core_output(input vec_t v, input int hold, input int oe_bytes);
    logic [255:0] exp;
    exp = 256'h0;
    for (int b = 0; b < 32; b++) begin
      if (b < oe_bytes) exp[255-8*b -: 8] = v.digest[255-8*b -: 8];
    end
    for (int k = 0; k < 3; k++) tick();
    for (int b = 0; b < 32; b++) begin
      bus.core_output_enable = (b < oe_bytes);
      bus.core_digest_byte   = (b < oe_bytes) ? v.digest[255-8*b -: 8] : 8'hEE;
      if (b == 31) chk("m_valid_early", bus.m_valid, 1'b0);
      tick();
    end
    bus.core_output_enable = 1'b0;
    bus.core_digest_byte   = 8'h00;
    chk("m_valid", bus.m_valid, 1'b1);
    chk("m_digest", bus.m_digest, exp);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_m_valid", bus.m_valid, 1'b1);
      chk("hold_m_digest", bus.m_digest, exp);
    end
    chk("done_busy", busy, 1'b1);
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    chk("idle_busy", busy, 1'b0);
    chk("idle_m_valid", bus.m_valid, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input int hold, input int oe_bytes);
    push_words(v);
    check_send(v, 16);
    chk("send_end", bus.core_data_valid, 1'b0);
    if (v.last) core_output(v, hold, oe_bytes);
    else core_inner();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks   = 0;
    failures = 0;

    // Vector table.
    vecs[0].blk       = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    vecs[0].last      = 1'b1;
    vecs[0].exp_first = 1'b1;
    vecs[0].exp_last  = 1'b1;
    vecs[0].toggle    = 1'b0;
    vecs[0].digest    = 256'hBA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD;

    vecs[1].blk       = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    vecs[1].last      = 1'b0;
    vecs[1].exp_first = 1'b1;
    vecs[1].exp_last  = 1'b0;
    vecs[1].toggle    = 1'b0;
    vecs[1].digest    = 256'h0;

    vecs[2].blk       = {{15{32'h00000000}}, 32'h000001c0};
    vecs[2].last      = 1'b1;
    vecs[2].exp_first = 1'b0;
    vecs[2].exp_last  = 1'b1;
    vecs[2].toggle    = 1'b0;
    vecs[2].digest    = 256'h248D6A61D20638B8E5C026930C3E6039A33CE45964FF2167F6ECEDD419DB06C1;

    vecs[3].blk       = 512'h0;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] iv;
      iv = i;
      vecs[3].blk[511-32*i -: 32] = {iv[7:0], 8'hC3, 8'(8'd15 - iv[7:0]), 8'h5A};
    end
    vecs[3].last      = 1'b1;
    vecs[3].exp_first = 1'b1;
    vecs[3].exp_last  = 1'b1;
    vecs[3].toggle    = 1'b1;
    vecs[3].digest    = 256'h0;
    for (int b = 0; b < 32; b++) begin
      logic [7:0] bv;
      bv = 8'h40 + 8'(b);
      vecs[3].digest[255-8*b -: 8] = bv;
    end

    // Reset, with the core reporting busy so IDLE must hold.
    reset_n                = 1'b1;
    bus.s_valid            = 1'b0;
    bus.s_data             = 32'h0;
    bus.s_last             = 1'b0;
    bus.core_busy          = 1'b1;
    bus.core_inner_busy    = 1'b0;
    bus.core_output_enable = 1'b0;
    bus.core_digest_byte   = 8'h00;
    bus.m_ready            = 1'b0;
    #2 reset_n = 1'b0;
    tick();
    chk("rst_s_ready", bus.s_ready, 1'b0);
    chk("rst_core_valid", bus.core_data_valid, 1'b0);
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_m_digest", bus.m_digest, 256'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", timeout_err, 1'b0);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("idle_core_busy_s_ready", bus.s_ready, 1'b0);
    chk("idle_core_busy_busy", busy, 1'b0);
    bus.core_busy = 1'b0;
    tick();
    chk("idle_to_fill", bus.s_ready, 1'b1);

    // Table: abc, two-block message, toggling upstream.
    for (int v = 0; v < 4; v++) begin
      run_vec(vecs[v], 0, 32);
    end

    // Downstream stalls for 10 cycles in DONE.
    run_vec(vecs[0], 10, 32);

    // Output window ends after 20 bytes; the rest must read as zero.
    run_vec(vecs[3], 0, 20);

    // Core never opens its output window.
    push_words(vecs[0]);
    check_send(vecs[0], 16);
    n = 0;
    while (!timeout_err && n < 400) begin
      tick();
      n++;
    end
    chk("timeout_latency", n, TIMEOUT_CYCLES);
    chk("timeout_busy_same", busy, 1'b1);
    tick();
    chk("timeout_pulse_end", timeout_err, 1'b0);
    chk("timeout_busy_after", busy, 1'b0);

    // Reset in the middle of a non-first block's SEND.
    run_vec(vecs[1], 0, 32);
    push_words(vecs[2]);
    check_send(vecs[2], 7);
    chk("pre_reset_valid", bus.core_data_valid, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_core_valid", bus.core_data_valid, 1'b0);
    chk("async_core_data", bus.core_data, 32'h0);
    chk("async_busy", busy, 1'b0);
    chk("async_m_digest", bus.m_digest, 256'h0);
    chk("async_timeout", timeout_err, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    run_vec(vecs[0], 0, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
